// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and the default bit period.
// The transmitter imports the same package so both ends agree on encodings.
// CLKS_PER_BIT default targets 115200 baud from a 25 MHz clock.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Latency: 2 clk cycles. RST_VAL sets the flop value held during reset.
// No backpressure; output follows input after two edges.
module uart_rx_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; first stage may go metastable, second resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronise RX, find start, sample mid-bit, LSB first.
// Latency: 2-cycle synchroniser, byte presented the cycle after stop sample.
// One-deep valid/ready holding register; a byte arriving while full is dropped with overrun.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_T = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_T  = CW'(CLKS_PER_BIT - 1);

  logic          rxs;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          done, done_d;
  logic          ferr_d;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start.
  uart_rx_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX),
    .q   (rxs)
  );

  // FSM and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shreg     <= shreg_d;
      done      <= done_d;
      frame_err <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling and stop-bit checking.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_T) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;  // glitch: line came back high before mid-start
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_T) begin
          cnt_d          = '0;
          shreg_d[idx]   = rxs;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_T) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = BREAK;  // byte discarded, wait for line release
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: load on completion if empty or being drained this cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
